// File: rtl/prbs_pkg.sv
// Shared PRBS-7 definitions: polynomial taps, word-level sequence helpers and checker FSM encoding.
package prbs_pkg;

    localparam int PRBS7_TAP_A = 7;
    localparam int PRBS7_TAP_B = 6;
    localparam int HB_BITS     = 22;

    typedef enum logic {
        HUNT = 1'b0,
        LOCK = 1'b1
    } state_t;

    // seq[0] is the oldest state bit (state[6]); output bit 15 is the first new bit.
    function automatic logic [15:0] prbs7_next16(input logic [6:0] state);
        logic [22:0] seq;
        logic [15:0] w;
        seq = '0;
        w   = '0;
        for (int i = 0; i < 7; i++) seq[i] = state[6-i];
        for (int i = 7; i < 23; i++) seq[i] = seq[i-PRBS7_TAP_A] ^ seq[i-PRBS7_TAP_B];
        for (int j = 0; j < 16; j++) w[15-j] = seq[7+j];
        return w;
    endfunction

    function automatic logic [4:0] popcount16(input logic [15:0] v);
        logic [4:0] c;
        c = '0;
        for (int i = 0; i < 16; i++) c = c + 5'(v[i]);
        return c;
    endfunction

endpackage

// File: rtl/led_stretch.sv
// Retriggerable pulse stretcher for front-panel LEDs: output stays lit STRETCH clocks after the last trigger.
module led_stretch #(
    parameter int STRETCH = 4000000
) (
    input  logic tmb_clock0,
    input  logic reset,
    input  logic trig,
    output logic led
);

    localparam int CW = $clog2(STRETCH + 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge tmb_clock0) begin
        if (reset)
            cnt <= '0;
        else if (trig)
            cnt <= CW'(STRETCH);
        else if (cnt != '0)
            cnt <= cnt - CW'(1);
    end

    assign led = (cnt != '0);

endmodule

// File: rtl/prbs7_rx_checker.sv
// Self-synchronising PRBS-7 word checker with lock FSM, saturating error/word counters and LED status.
module prbs7_rx_checker
    import prbs_pkg::*;
#(
    parameter int LOCK_GOOD  = 64,
    parameter int UNLOCK_BAD = 8,
    parameter int STRETCH    = 4000000,
    parameter int CNT_W      = 32
) (
    input  logic             tmb_clock0,
    input  logic             reset,
    input  logic             clear_cnt,
    input  logic [15:0]      rx_data,
    input  logic             rx_valid,
    output logic             locked,
    output logic             err_word,
    output logic [CNT_W-1:0] err_bits_cnt,
    output logic [CNT_W-1:0] word_cnt,
    output logic [3:0]       unlock_cnt,
    output logic [7:0]       led_fp
);

    localparam int GR_W = $clog2(LOCK_GOOD + 1);
    localparam int BR_W = $clog2(UNLOCK_BAD + 1);

    state_t           state, state_nxt;
    logic [6:0]       prev_rx, prev_nxt;
    logic             has_prev, has_prev_nxt;
    logic [GR_W-1:0]  good_run, good_nxt, gr_inc;
    logic [BR_W-1:0]  bad_run, bad_nxt, br_inc;
    logic [15:0]      exp_state, exp_nxt, expected_h;
    logic [CNT_W-1:0] err_bits_nxt, word_nxt;
    logic [CNT_W:0]   err_sum;
    logic [3:0]       unlock_nxt;
    logic             err_word_nxt, good_word;
    logic [4:0]       pop;
    logic [HB_BITS:0] hb_cnt;
    logic             err_led, act_led;

    always_comb begin
        state_nxt    = state;
        prev_nxt     = prev_rx;
        has_prev_nxt = has_prev;
        good_nxt     = good_run;
        bad_nxt      = bad_run;
        exp_nxt      = exp_state;
        err_bits_nxt = err_bits_cnt;
        word_nxt     = word_cnt;
        unlock_nxt   = unlock_cnt;
        err_word_nxt = 1'b0;

        // A zero seed would predict all-zero words forever, so it never counts as good.
        expected_h = prbs7_next16(prev_rx);
        good_word  = has_prev && (prev_rx != '0) && (rx_data == expected_h);
        gr_inc     = good_word ? good_run + GR_W'(1) : '0;
        pop        = popcount16(rx_data ^ exp_state);
        br_inc     = (pop != '0) ? bad_run + BR_W'(1) : '0;
        err_sum    = {1'b0, err_bits_cnt} + (CNT_W+1)'(pop);

        if (rx_valid) begin
            case (state)
                HUNT: begin
                    prev_nxt     = rx_data[6:0];
                    has_prev_nxt = 1'b1;
                    if (gr_inc == GR_W'(LOCK_GOOD)) begin
                        state_nxt = LOCK;
                        exp_nxt   = prbs7_next16(rx_data[6:0]);
                        good_nxt  = '0;
                        bad_nxt   = '0;
                    end else begin
                        good_nxt = gr_inc;
                    end
                end
                LOCK: begin
                    // Free-running reference: a corrupted word must not reseed it.
                    exp_nxt      = prbs7_next16(exp_state[6:0]);
                    word_nxt     = (word_cnt == '1) ? word_cnt : word_cnt + CNT_W'(1);
                    err_bits_nxt = err_sum[CNT_W] ? '1 : err_sum[CNT_W-1:0];
                    err_word_nxt = (pop != '0);
                    if (br_inc == BR_W'(UNLOCK_BAD)) begin
                        state_nxt    = HUNT;
                        unlock_nxt   = (unlock_cnt == 4'hF) ? unlock_cnt : unlock_cnt + 4'd1;
                        good_nxt     = '0;
                        bad_nxt      = '0;
                        has_prev_nxt = 1'b0;
                    end else begin
                        bad_nxt = br_inc;
                    end
                end
                default: state_nxt = HUNT;
            endcase
        end

        if (clear_cnt) begin
            err_bits_nxt = '0;
            word_nxt     = '0;
            unlock_nxt   = '0;
        end
    end

    always_ff @(posedge tmb_clock0) begin
        if (reset) begin
            state        <= HUNT;
            prev_rx      <= '0;
            has_prev     <= 1'b0;
            good_run     <= '0;
            bad_run      <= '0;
            exp_state    <= '0;
            err_bits_cnt <= '0;
            word_cnt     <= '0;
            unlock_cnt   <= '0;
            err_word     <= 1'b0;
        end else begin
            state        <= state_nxt;
            prev_rx      <= prev_nxt;
            has_prev     <= has_prev_nxt;
            good_run     <= good_nxt;
            bad_run      <= bad_nxt;
            exp_state    <= exp_nxt;
            err_bits_cnt <= err_bits_nxt;
            word_cnt     <= word_nxt;
            unlock_cnt   <= unlock_nxt;
            err_word     <= err_word_nxt;
        end
    end

    always_ff @(posedge tmb_clock0) begin
        if (reset)
            hb_cnt <= '0;
        else
            hb_cnt <= hb_cnt + (HB_BITS+1)'(1);
    end

    assign locked = (state == LOCK);

    led_stretch #(.STRETCH(STRETCH)) u_err_led (
        .tmb_clock0 (tmb_clock0),
        .reset      (reset),
        .trig       (err_word),
        .led        (err_led)
    );

    led_stretch #(.STRETCH(STRETCH)) u_act_led (
        .tmb_clock0 (tmb_clock0),
        .reset      (reset),
        .trig       (rx_valid),
        .led        (act_led)
    );

    assign led_fp = {unlock_cnt, hb_cnt[HB_BITS], act_led, err_led, locked};

endmodule
